// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master round-robin memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/mem_arbiter_wdog.sv
// Transaction watchdog: flags the cycle in which a granted transaction has
// waited TIMEOUT_CYCLES cycles without slave completion. Used with ARB_TIMEOUT_EN.
module mem_arbiter_wdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic active,
  input  logic done,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] count_r;

  // count stalled granted cycles; expired is pre-computed so it is high in
  // the cycle where the stall count reaches TIMEOUT_CYCLES
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= '0;
      expired <= 1'b0;
    end else if (start) begin
      count_r <= '0;
      expired <= (LIMIT == '0);
    end else if (active && !done) begin
      count_r <= count_r + ONE;
      expired <= ((count_r + ONE) == LIMIT);
    end else begin
      count_r <= count_r;
      expired <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter letting two valid/ready masters share one memory slave.
// Optional transaction watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ready,
  output logic [1:0]          grant,
  output logic                err
);

  state_t            state_r;
  state_t            state_next_s;
  logic              last_grant_r;
  logic              last_grant_next_s;
  logic              owner_s;
  logic              own_valid_s;
  logic              expired_s;
  logic [DATA_W-1:0] timeout_rdata_s;
  logic [DATA_W-1:0] done_rdata_s;

`ifdef ARB_TIMEOUT_EN
  localparam int REP = (DATA_W + 31) / 32;
  localparam logic [REP*32-1:0] TIMEOUT_REP = {REP{TIMEOUT_RDATA}};

  logic start_s;
  logic active_s;
  logic done_s;

  assign start_s         = (state_r == IDLE) && (state_next_s != IDLE);
  assign active_s        = (state_r != IDLE);
  assign done_s          = s_valid && s_ready;
  assign timeout_rdata_s = TIMEOUT_REP[DATA_W-1:0];

  mem_arbiter_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .start  (start_s),
    .active (active_s),
    .done   (done_s),
    .expired(expired_s)
  );
`else
  assign expired_s       = 1'b0;
  assign timeout_rdata_s = '0;
`endif

  // state register and round-robin pointer; last_grant=1 lets m0 win the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
    end else begin
      state_r      <= state_next_s;
      last_grant_r <= last_grant_next_s;
    end
  end

  // next-state decision and the combinational slave/master pass-through
  always_comb begin
    state_next_s      = state_r;
    last_grant_next_s = last_grant_r;
    s_valid           = 1'b0;
    s_addr            = '0;
    s_wdata           = '0;
    s_wstrb           = '0;
    grant             = GRANT_NONE;
    m0_ready          = 1'b0;
    m0_rdata          = '0;
    m1_ready          = 1'b0;
    m1_rdata          = '0;
    err               = 1'b0;
    done_rdata_s      = '0;
    owner_s           = (state_r == G1);
    own_valid_s       = owner_s ? m1_valid : m0_valid;

    // outputs are forced quiet while reset is held
    if (reset) begin
      state_next_s      = IDLE;
      last_grant_next_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (m0_valid && (!m1_valid || last_grant_r)) begin
            state_next_s = G0;
          end else if (m1_valid) begin
            state_next_s = G1;
          end else begin
            state_next_s = IDLE;
          end
        end
        G0, G1: begin
          grant   = owner_s ? GRANT_M1 : GRANT_M0;
          s_addr  = owner_s ? m1_addr  : m0_addr;
          s_wdata = owner_s ? m1_wdata : m0_wdata;
          s_wstrb = owner_s ? m1_wstrb : m0_wstrb;
          if (!own_valid_s) begin
            // master withdrew: drop the request without completing it
            state_next_s = IDLE;
          end else if (s_ready || expired_s) begin
            s_valid           = s_ready;
            err               = !s_ready;
            done_rdata_s      = s_ready ? s_rdata : timeout_rdata_s;
            state_next_s      = IDLE;
            last_grant_next_s = owner_s;
            if (owner_s) begin
              m1_ready = 1'b1;
              m1_rdata = done_rdata_s;
            end else begin
              m0_ready = 1'b1;
              m0_rdata = done_rdata_s;
            end
          end else begin
            s_valid = 1'b1;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester, one-slave arbiter for the valid/ready memory bus.
- Lets the CPU data port (m0) and a second master (m1, e.g. DMA or debug loader) share one single-port memory slave (RAM or FRAM).
- Scheme: round-robin, one transaction in flight, no reordering.
- Sits between the masters and the slave's valid/addr/wdata/wstrb/rdata/ready interface.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_valid  in  1  master 0 request
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_wstrb  in  DATA_W/8  master 0 byte strobes; all-zero means read
- m0_rdata  out  DATA_W  master 0 read data
- m0_ready  out  1  master 0 completion pulse
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_ready  same as m0, for master 1
- s_valid  out  1  slave request
- s_addr  out  ADDR_W  slave address
- s_wdata  out  DATA_W  slave write data
- s_wstrb  out  DATA_W/8  slave byte strobes
- s_rdata  in  DATA_W  slave read data
- s_ready  in  1  slave completion
- grant  out  2  one-hot current owner; 00 when idle
- err  out  1  timeout pulse; tied 0 when the feature is compiled out

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Master protocol: a master holds valid, addr, wdata and wstrb stable until it sees ready. Ready is a single-cycle pulse.
- Reset:
  - state=IDLE, last_grant=1, so m0 wins the first tie.
  - All outputs 0: s_valid, s_addr, s_wdata, s_wstrb, mi_ready, mi_rdata, grant, err.
  - Reset asserted mid-transaction aborts it: no ready is returned, and the next cycle is IDLE with s_valid=0.
- IDLE:
  - s_valid=0, grant=00, all mi_ready=0.
  - Only m0_valid set: next state G0. Only m1_valid set: next state G1.
  - Both set: grant the master that is not last_grant.
  - The grant decision is registered, so there is one bubble cycle after each request.
- Gi (i=0,1):
  - grant=onehot(i).
  - s_valid = mi_valid; s_addr, s_wdata, s_wstrb are combinational pass-through from master i.
  - On s_valid && s_ready in the same cycle:
    - mi_ready=1 and mi_rdata=s_rdata, both combinational, that cycle only.
    - last_grant<=i; next state IDLE.
- Non-granted master: ready=0 and rdata=0 at all times.
- s_ready while s_valid=0: ignored.
- Granted master drops valid before ready (protocol violation): s_valid falls the same cycle, next state IDLE, last_grant unchanged, no ready issued.
- Latency and throughput:
  - Request at cycle t gives grant and s_valid at t+1.
  - With a zero-wait slave, mi_ready fires at t+1.
  - Peak throughput is one transaction per 2 cycles, because IDLE sits between transactions.
- Fairness: with both masters requesting continuously, service strictly alternates. Neither waits more than one foreign transaction.
- Idle output values: s_addr, s_wdata and s_wstrb are driven 0 in IDLE.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to Gi and increments every Gi cycle without s_ready.
  - When the count reaches TIMEOUT_CYCLES: mi_ready=1, mi_rdata=32'hDEAD_BEEF (replicated to DATA_W), err=1 for one cycle, s_valid=0 that cycle, next state IDLE, last_grant<=i.
  - If s_ready arrives in the same cycle as the timeout, the normal completion wins and err=0.
- Undefined: no counter; Gi waits indefinitely; err tied 0.

Decomposition:
- Package mem_arbiter_pkg holds:
  - state enum {IDLE, G0, G1};
  - TIMEOUT_RDATA constant 32'hDEAD_BEEF;
  - the grant one-hot encodings.
- Sub-module mem_arbiter_wdog holds the timeout counter. Inputs: clk, reset, start, active, done. Output: expired. It is instantiated only under ARB_TIMEOUT_EN.
- Everything else lives in mem_arbiter.

Test Plan:
- Single read: reset for 2 cycles; m0_valid, addr 0x2000_0010, wstrb 0; slave returns ready one cycle after s_valid with rdata 0x1234_5678 -> grant=01 at t+1; m0_ready pulses at t+2 with m0_rdata 0x1234_5678; m1_ready stays 0.
- Tie after reset: m0 and m1 both assert valid at the same cycle; zero-wait slave -> m0 served first, then IDLE, then m1. Order is 01,00,10, repeating alternately while both stay asserted.
- Write pass-through: m1 writes wdata 0xCAFE_F00D, wstrb 4'b0011 -> s_wdata and s_wstrb match exactly while grant=10; m0 pending during it sees no ready.
- Abort: m0 granted, slave stalls, m0 drops valid -> s_valid=0 the same cycle, IDLE next, no m0_ready; a later tie still goes to m0.
- Reset mid-transaction: m1 granted, slave stalled, reset pulsed -> next cycle all outputs 0, grant=00; a following tie is granted to m0.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4: slave never ready -> m0_ready and err pulse after 4 granted cycles with rdata 0xDEAD_BEEF. Repeat with s_ready on cycle 4 -> normal rdata, err=0.
